// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game geometry, enemy AI tuning defaults and LFSR helper
// Coordinates are centre-origin signed. MAP_* and PLAYER_*/BULLET_* are half-extents.
package game_pkg;

  localparam int MAP_X    = 320;
  localparam int MAP_Y    = 240;
  localparam int PLAYER_X = 16;
  localparam int PLAYER_Y = 16;
  localparam int BULLET_X = 4;
  localparam int BULLET_Y = 4;

  localparam int ENEMY_X_DEF       = MAP_X - 3 * PLAYER_X;
  localparam int STEP_Y_DEF        = 4;
  localparam int ALIGN_TOL_DEF     = 8;
  localparam int AIM_DELAY_DEF     = 8;
  localparam int AIM_JITTER_EN_DEF = 1;
  localparam int COOLDOWN_CYC_DEF  = 30;
  localparam int DEFEND_CYC_DEF    = 20;
  localparam int THREAT_DIST_DEF   = 64;
  localparam int DEFEND_THRESH_DEF = 16;

  localparam int          CNT_W         = 8;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TRACK    = 3'd1,
    AIM      = 3'd2,
    FIRE     = 3'd3,
    DEFEND   = 3'd4,
    COOLDOWN = 3'd5
  } enemy_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with enable and seed
// Ports: clk, rst (sync, active-high), en (advance once per enabled cycle),
//        rnd[3:0] (low nibble of the current LFSR value).
import game_pkg::*;

module lfsr16 #(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] rnd
);

  // An all-zero seed would lock the register, so substitute the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_SEED_DEF : SEED;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_EFF;
    end else if (en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign rnd = lfsr_q[3:0];

endmodule

// File: rtl/enemy_ai_ctrl.sv
// rtl/enemy_ai_ctrl.sv - enemy AI: tracks player y, aims, fires, defends, cools down
// Ports: clk, rst (sync, active-high), en (freeze when low), yPlayer,
//        bullet_active (enemy bullet in flight), pb_valid/pb_x/pb_y (player bullet),
//        attack (one-cycle fire request), defend (shield), xEnemy/yEnemy (enemy centre),
//        state (current FSM state).
import game_pkg::*;

module enemy_ai_ctrl #(
  parameter int          ENEMY_X       = ENEMY_X_DEF,
  parameter int          STEP_Y        = STEP_Y_DEF,
  parameter int          ALIGN_TOL     = ALIGN_TOL_DEF,
  parameter int          AIM_DELAY     = AIM_DELAY_DEF,
  parameter int          AIM_JITTER_EN = AIM_JITTER_EN_DEF,
  parameter int          COOLDOWN_CYC  = COOLDOWN_CYC_DEF,
  parameter int          DEFEND_CYC    = DEFEND_CYC_DEF,
  parameter int          THREAT_DIST   = THREAT_DIST_DEF,
  parameter int          DEFEND_THRESH = DEFEND_THRESH_DEF,
  parameter logic [15:0] SEED          = LFSR_SEED_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [9:0]  yPlayer,
  input  logic               bullet_active,
  input  logic               pb_valid,
  input  logic signed [10:0] pb_x,
  input  logic signed [9:0]  pb_y,
  output logic               attack,
  output logic               defend,
  output logic signed [10:0] xEnemy,
  output logic signed [9:0]  yEnemy,
  output logic [2:0]         state
);

  localparam logic [2:0] ST_IDLE     = 3'(IDLE);
  localparam logic [2:0] ST_TRACK    = 3'(TRACK);
  localparam logic [2:0] ST_AIM      = 3'(AIM);
  localparam logic [2:0] ST_FIRE     = 3'(FIRE);
  localparam logic [2:0] ST_DEFEND   = 3'(DEFEND);
  localparam logic [2:0] ST_COOLDOWN = 3'(COOLDOWN);

  localparam logic [CNT_W-1:0] DEF_LOAD  = CNT_W'(DEFEND_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] AIM_BASE  = CNT_W'(AIM_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Threat window edges, 12-bit signed so no sum or difference can wrap.
  localparam logic signed [11:0] THR_LO = 12'(ENEMY_X - PLAYER_X - THREAT_DIST);
  localparam logic signed [11:0] THR_HI = 12'(ENEMY_X + PLAYER_X);
  localparam logic signed [11:0] BX12   = 12'(BULLET_X);
  localparam logic signed [11:0] YR12   = 12'(PLAYER_Y + BULLET_Y);

  localparam logic signed [10:0] STEP11  = 11'(STEP_Y);
  localparam logic signed [10:0] TOL11   = 11'(ALIGN_TOL);
  localparam logic signed [10:0] Y_LIM   = 11'(MAP_Y - PLAYER_Y);
  localparam logic signed [10:0] Y_LIM_N = -11'(MAP_Y - PLAYER_Y);

  logic [3:0]       rnd;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] aim_load;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .rnd (rnd)
  );

  // Player bullet threat test.
  logic signed [11:0] pbx12, pby12, ye12, dyb, dyb_abs;
  logic               threat, def_entry;

  assign pbx12   = {pb_x[10], pb_x};
  assign pby12   = {{2{pb_y[9]}}, pb_y};
  assign ye12    = {{2{yEnemy[9]}}, yEnemy};
  assign dyb     = pby12 - ye12;
  assign dyb_abs = dyb[11] ? -dyb : dyb;

  assign threat = pb_valid
               && (pbx12 + BX12 >= THR_LO)
               && (pbx12 - BX12 <= THR_HI)
               && (dyb_abs <= YR12);

  assign def_entry = threat && ({1'b0, rnd} < 5'(DEFEND_THRESH));

  assign aim_load = AIM_BASE + ((AIM_JITTER_EN != 0) ? CNT_W'(rnd) : '0);

  // Vertical tracking: step toward the player, snap when within one step, clamp to the map.
  logic signed [10:0] yp11, ye11, dy, ady, ymove, yclamp;
  logic               aligned;

  assign yp11    = {yPlayer[9], yPlayer};
  assign ye11    = {yEnemy[9], yEnemy};
  assign dy      = yp11 - ye11;
  assign ady     = dy[10] ? -dy : dy;
  assign aligned = (ady <= TOL11);

  always_comb begin
    ymove  = ye11;
    yclamp = ye11;
    if (ady < STEP11) begin
      ymove = yp11;
    end else if (dy[10]) begin
      ymove = ye11 - STEP11;
    end else begin
      ymove = ye11 + STEP11;
    end
    if (ymove > Y_LIM) begin
      yclamp = Y_LIM;
    end else if (ymove < Y_LIM_N) begin
      yclamp = Y_LIM_N;
    end else begin
      yclamp = ymove;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      yEnemy <= '0;
      cnt    <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: state <= ST_TRACK;

        ST_TRACK: begin
          if (def_entry) begin
            state <= ST_DEFEND;
            cnt   <= DEF_LOAD;
          end else begin
            yEnemy <= 10'(yclamp);
            // Alignment uses the distance before this cycle's move.
            if (aligned && !bullet_active) begin
              state <= ST_AIM;
              cnt   <= aim_load;
            end
          end
        end

        ST_AIM: begin
          if (def_entry) begin
            state <= ST_DEFEND;
            cnt   <= DEF_LOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (!bullet_active) begin
            state <= ST_FIRE;
          end
        end

        ST_FIRE: begin
          state <= ST_COOLDOWN;
          cnt   <= COOL_LOAD;
        end

        // Fresh threats do not extend the hold.
        ST_DEFEND: begin
          if (cnt == '0) begin
            state <= ST_COOLDOWN;
            cnt   <= COOL_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_COOLDOWN: begin
          if (def_entry) begin
            state <= ST_DEFEND;
            cnt   <= DEF_LOAD;
          end else if (cnt == '0) begin
            state <= ST_TRACK;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // attack is gated by en so a frozen FIRE state never re-requests a shot.
  assign attack = en && (state == ST_FIRE);
  assign defend = (state == ST_DEFEND);
  assign xEnemy = 11'(ENEMY_X);

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// tb/tb_enemy_ai_ctrl.sv - self-checking bench for enemy_ai_ctrl
import game_pkg::*;

module tb_enemy_ai_ctrl;

  localparam int EX    = MAP_X - 3 * PLAYER_X;
  localparam int YLIM  = MAP_Y - PLAYER_Y;
  localparam int T_IDLE = 0, T_TRACK = 1, T_AIM = 2, T_FIRE = 3, T_DEF = 4, T_COOL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, bullet_active, pb_valid;
  logic signed [9:0]  yPlayer, pb_y;
  logic signed [10:0] pb_x;
  logic               attack, defend, attack2, defend2;
  logic signed [10:0] xEnemy, xEnemy2;
  logic signed [9:0]  yEnemy, yEnemy2;
  logic [2:0]         state, state2;

  enemy_ai_ctrl #(.AIM_JITTER_EN(0), .DEFEND_THRESH(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .yPlayer(yPlayer), .bullet_active(bullet_active),
    .pb_valid(pb_valid), .pb_x(pb_x), .pb_y(pb_y), .attack(attack), .defend(defend),
    .xEnemy(xEnemy), .yEnemy(yEnemy), .state(state)
  );

  enemy_ai_ctrl #(.AIM_JITTER_EN(1), .DEFEND_THRESH(0)) u_nod (
    .clk(clk), .rst(rst), .en(en), .yPlayer(yPlayer), .bullet_active(bullet_active),
    .pb_valid(pb_valid), .pb_x(pb_x), .pb_y(pb_y), .attack(attack2), .defend(defend2),
    .xEnemy(xEnemy2), .yEnemy(yEnemy2), .state(state2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          st;
    int          y;
    int          cnt;
    logic [15:0] lf;
  } mdl_t;

  mdl_t m0, m1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic mdl_t mreset();
    mdl_t s;
    s.st = T_IDLE; s.y = 0; s.cnt = 0; s.lf = 16'hACE1;
    return s;
  endfunction

  // Reference behaviour for one enabled cycle, written from the game rules.
  function automatic mdl_t mstep(input mdl_t s, input int jit, input int thr, input int yp,
                                 input bit ba, input bit pv, input int px, input int py);
    mdl_t n;
    bit   hit, dfd;
    int   dy;
    n   = s;
    hit = pv && (px + BULLET_X >= EX - PLAYER_X - 64) && (px - BULLET_X <= EX + PLAYER_X)
             && (iabs(py - s.y) <= PLAYER_Y + BULLET_Y);
    dfd = hit && (int'(s.lf[3:0]) < thr);
    case (s.st)
      T_IDLE: n.st = T_TRACK;
      T_TRACK: begin
        if (dfd) begin
          n.st = T_DEF; n.cnt = 19;
        end else begin
          dy = yp - s.y;
          if (iabs(dy) < 4) n.y = yp;
          else n.y = s.y + ((dy > 0) ? 4 : -4);
          if (n.y > YLIM) n.y = YLIM;
          if (n.y < -YLIM) n.y = -YLIM;
          if (iabs(dy) <= 8 && !ba) begin
            n.st = T_AIM; n.cnt = 7 + (jit != 0 ? int'(s.lf[3:0]) : 0);
          end
        end
      end
      T_AIM: begin
        if (dfd) begin n.st = T_DEF; n.cnt = 19; end
        else if (s.cnt != 0) n.cnt = s.cnt - 1;
        else if (!ba) n.st = T_FIRE;
      end
      T_FIRE: begin n.st = T_COOL; n.cnt = 29; end
      T_DEF: begin
        if (s.cnt == 0) begin n.st = T_COOL; n.cnt = 29; end
        else n.cnt = s.cnt - 1;
      end
      default: begin
        if (dfd) begin n.st = T_DEF; n.cnt = 19; end
        else if (s.cnt == 0) n.st = T_TRACK;
        else n.cnt = s.cnt - 1;
      end
    endcase
    n.lf = s.lf[0] ? ((s.lf >> 1) ^ 16'hB400) : (s.lf >> 1);
    return n;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m0 = mreset(); m1 = mreset();
    end else if (en) begin
      m0 = mstep(m0, 0, 16, int'(yPlayer), bullet_active, pb_valid, int'(pb_x), int'(pb_y));
      m1 = mstep(m1, 1, 0,  int'(yPlayer), bullet_active, pb_valid, int'(pb_x), int'(pb_y));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pb_valid = 1'b0; bullet_active = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; yPlayer = 10'sd100;
    cycle(); cycle();
    checks++; if (state !== 3'(T_IDLE)) begin errors++; $display("FAIL reset_state got %0d want %0d", state, T_IDLE); end
    checks++; if (attack !== 1'b0) begin errors++; $display("FAIL reset_attack got %b want 0", attack); end
    checks++; if (defend !== 1'b0) begin errors++; $display("FAIL reset_defend got %b want 0", defend); end
    checks++; if (int'(yEnemy) !== 0) begin errors++; $display("FAIL reset_y got %0d want 0", yEnemy); end
    checks++; if (int'(xEnemy) !== EX) begin errors++; $display("FAIL reset_x got %0d want %0d", xEnemy, EX); end
    checks++; if (u_dut.u_lfsr.lfsr_q !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr got %h want ace1", u_dut.u_lfsr.lfsr_q); end
    checks++; if (int'(u_dut.cnt) !== 0) begin errors++; $display("FAIL reset_cnt got %0d want 0", u_dut.cnt); end
    rst = 1'b0;
  endtask

  task automatic test_aligned_fire();
    int fire_at, n_att, n_cool;
    do_reset();
    en = 1'b1; yPlayer = '0; bullet_active = 1'b0; pb_valid = 1'b0;
    fire_at = -1; n_att = 0; n_cool = 0;
    for (int i = 1; i <= 45; i++) begin
      cycle();
      if (attack) begin n_att++; if (fire_at < 0) fire_at = i; end
      if (state == 3'(T_COOL)) n_cool++;
      if (i == 1) begin checks++; if (state !== 3'(T_TRACK)) begin errors++; $display("FAIL fire_track got %0d want %0d", state, T_TRACK); end end
      if (i == 2) begin checks++; if (state !== 3'(T_AIM)) begin errors++; $display("FAIL fire_aim got %0d want %0d", state, T_AIM); end end
      if (i == 41) begin checks++; if (state !== 3'(T_TRACK)) begin errors++; $display("FAIL fire_retrack got %0d want %0d", state, T_TRACK); end end
    end
    checks++; if (fire_at !== 10) begin errors++; $display("FAIL fire_cycle got %0d want 10", fire_at); end
    checks++; if (n_att !== 1) begin errors++; $display("FAIL fire_count got %0d want 1", n_att); end
    checks++; if (n_cool !== 30) begin errors++; $display("FAIL cooldown_len got %0d want 30", n_cool); end
  endtask

  task automatic test_tracking_clamp();
    do_reset();
    en = 1'b1; bullet_active = 1'b1; yPlayer = 10'sd40;
    cycle();
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++; if (int'(yEnemy) !== 4 * k) begin errors++; $display("FAIL track_step%0d got %0d want %0d", k, yEnemy, 4 * k); end
    end
    yPlayer = 10'sd511;
    repeat (60) cycle();
    checks++; if (int'(yEnemy) !== YLIM) begin errors++; $display("FAIL clamp_hi got %0d want %0d", yEnemy, YLIM); end
    checks++; if (state !== 3'(T_TRACK)) begin errors++; $display("FAIL busy_track got %0d want %0d", state, T_TRACK); end
    yPlayer = -10'sd512;
    repeat (120) cycle();
    checks++; if (int'(yEnemy) !== -YLIM) begin errors++; $display("FAIL clamp_lo got %0d want %0d", yEnemy, -YLIM); end
  endtask

  task automatic test_bullet_busy();
    int n_att;
    do_reset();
    en = 1'b1; bullet_active = 1'b0; yPlayer = '0; n_att = 0;
    cycle(); cycle();
    bullet_active = 1'b1;
    repeat (15) begin cycle(); if (attack) n_att++; end
    checks++; if (n_att !== 0) begin errors++; $display("FAIL busy_attack got %0d want 0", n_att); end
    checks++; if (state !== 3'(T_AIM)) begin errors++; $display("FAIL busy_aim got %0d want %0d", state, T_AIM); end
    checks++; if (int'(u_dut.cnt) !== 0) begin errors++; $display("FAIL busy_cnt got %0d want 0", u_dut.cnt); end
    bullet_active = 1'b0;
    cycle();
    checks++; if (attack !== 1'b1) begin errors++; $display("FAIL release_attack got %b want 1", attack); end
    cycle();
    checks++; if (attack !== 1'b0) begin errors++; $display("FAIL attack_single got %b want 0", attack); end
  endtask

  task automatic test_defend();
    int n_def, n_cool, n_def2;
    do_reset();
    en = 1'b1; bullet_active = 1'b1; yPlayer = '0;
    repeat (3) cycle();
    pb_valid = 1'b1; pb_x = 11'(EX - PLAYER_X - 10); pb_y = '0;
    n_def = 0; n_cool = 0; n_def2 = 0;
    for (int i = 1; i <= 51; i++) begin
      if (i == 11) pb_valid = 1'b0;
      cycle();
      if (defend) n_def++;
      if (defend2) n_def2++;
      if (state == 3'(T_COOL)) n_cool++;
      if (i == 1) begin checks++; if (defend !== 1'b1) begin errors++; $display("FAIL defend_entry got %b want 1", defend); end end
      if (i == 51) begin checks++; if (state !== 3'(T_TRACK)) begin errors++; $display("FAIL defend_exit got %0d want %0d", state, T_TRACK); end end
    end
    checks++; if (n_def !== 20) begin errors++; $display("FAIL defend_len got %0d want 20", n_def); end
    checks++; if (n_cool !== 30) begin errors++; $display("FAIL defend_cool got %0d want 30", n_cool); end
    checks++; if (n_def2 !== 0) begin errors++; $display("FAIL thresh0_defend got %0d want 0", n_def2); end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    en = 1'b1; bullet_active = 1'b0; yPlayer = 10'sd20;
    for (int i = 0; i < 20 && m0.st != T_AIM; i++) cycle();
    cycle(); cycle();
    checks++; if (state !== 3'(T_AIM)) begin errors++; $display("FAIL freeze_pre got %0d want %0d", state, T_AIM); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (int'(u_dut.cnt) !== m0.cnt) begin errors++; $display("FAIL freeze_cnt got %0d want %0d", u_dut.cnt, m0.cnt); end
      checks++; if (u_dut.u_lfsr.lfsr_q !== m0.lf) begin errors++; $display("FAIL freeze_lfsr got %h want %h", u_dut.u_lfsr.lfsr_q, m0.lf); end
      checks++; if (int'(yEnemy) !== m0.y) begin errors++; $display("FAIL freeze_y got %0d want %0d", yEnemy, m0.y); end
      checks++; if (state !== 3'(T_AIM)) begin errors++; $display("FAIL freeze_state got %0d want %0d", state, T_AIM); end
    end
    en = 1'b1;
    for (int i = 0; i < 40 && m0.st != T_FIRE; i++) cycle();
    checks++; if (attack !== 1'b1) begin errors++; $display("FAIL freeze_fire got %b want 1", attack); end
    en = 1'b0;
    #1;
    checks++; if (attack !== 1'b0) begin errors++; $display("FAIL frozen_attack got %b want 0", attack); end
    cycle();
    en = 1'b1;
    cycle();
    checks++; if (state !== 3'(T_COOL)) begin errors++; $display("FAIL fire_to_cool got %0d want %0d", state, T_COOL); end
    pb_valid = 1'b1; pb_x = 11'(EX - PLAYER_X - 10); pb_y = 10'(m0.y);
    cycle();
    checks++; if (defend !== 1'b1) begin errors++; $display("FAIL cool_defend got %b want 1", defend); end
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    checks++; if (state !== 3'(T_IDLE)) begin errors++; $display("FAIL midrst_state got %0d want %0d", state, T_IDLE); end
    checks++; if (defend !== 1'b0) begin errors++; $display("FAIL midrst_defend got %b want 0", defend); end
    checks++; if (int'(yEnemy) !== 0) begin errors++; $display("FAIL midrst_y got %0d want 0", yEnemy); end
    rst = 1'b0; pb_valid = 1'b0;
  endtask

  task automatic test_random();
    logic prev_att;
    do_reset();
    prev_att = 1'b0;
    yPlayer = '0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) yPlayer = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) bullet_active = ~bullet_active;
      pb_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) pb_x = 11'($urandom_range(0, 2047));
      else pb_x = 11'(EX - 100 + int'($urandom_range(0, 140)));
      pb_y = 10'(m0.y + int'($urandom_range(0, 50)) - 25);
      cycle();
      checks++; if (int'(state) !== m0.st) begin errors++; $display("FAIL rnd_state i=%0d got %0d want %0d", i, state, m0.st); end
      checks++; if (attack !== ((m0.st == T_FIRE) && en)) begin errors++; $display("FAIL rnd_attack i=%0d got %b want %b", i, attack, (m0.st == T_FIRE) && en); end
      checks++; if (defend !== (m0.st == T_DEF)) begin errors++; $display("FAIL rnd_defend i=%0d got %b want %b", i, defend, m0.st == T_DEF); end
      checks++; if (int'(yEnemy) !== m0.y) begin errors++; $display("FAIL rnd_y i=%0d got %0d want %0d", i, yEnemy, m0.y); end
      checks++; if (int'(xEnemy) !== EX) begin errors++; $display("FAIL rnd_x i=%0d got %0d want %0d", i, xEnemy, EX); end
      checks++; if (int'(u_dut.cnt) !== m0.cnt) begin errors++; $display("FAIL rnd_cnt i=%0d got %0d want %0d", i, u_dut.cnt, m0.cnt); end
      checks++; if (u_dut.u_lfsr.lfsr_q !== m0.lf) begin errors++; $display("FAIL rnd_lfsr i=%0d got %h want %h", i, u_dut.u_lfsr.lfsr_q, m0.lf); end
      checks++; if (int'(state2) !== m1.st) begin errors++; $display("FAIL rnd_state2 i=%0d got %0d want %0d", i, state2, m1.st); end
      checks++; if (int'(yEnemy2) !== m1.y) begin errors++; $display("FAIL rnd_y2 i=%0d got %0d want %0d", i, yEnemy2, m1.y); end
      checks++; if (attack2 !== ((m1.st == T_FIRE) && en)) begin errors++; $display("FAIL rnd_attack2 i=%0d got %b", i, attack2); end
      checks++; if (defend2 !== 1'b0) begin errors++; $display("FAIL rnd_defend2 i=%0d got %b want 0", i, defend2); end
      checks++; if (int'(xEnemy2) !== EX) begin errors++; $display("FAIL rnd_x2 i=%0d got %0d want %0d", i, xEnemy2, EX); end
      checks++; if (attack && defend) begin errors++; $display("FAIL rnd_att_def i=%0d got both high want exclusive", i); end
      checks++; if (attack && prev_att) begin errors++; $display("FAIL rnd_att_twice i=%0d got two consecutive want single", i); end
      prev_att = attack;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; yPlayer = '0; bullet_active = 1'b0;
    pb_valid = 1'b0; pb_x = '0; pb_y = '0;
    m0 = mreset(); m1 = mreset();
    test_reset();
    test_aligned_fire();
    test_tracking_clamp();
    test_bullet_busy();
    test_defend();
    test_freeze_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
